// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: instruction fields, opcodes,
// station tag ranges and the issue-stage state encoding.
package tomasulo_pkg;

    localparam int unsigned TAG_W = 3;
    localparam int unsigned REG_W = 3;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 9;
    localparam int unsigned RS_MSB = 8;
    localparam int unsigned RS_LSB = 6;
    localparam int unsigned RT_MSB = 5;
    localparam int unsigned RT_LSB = 3;

    localparam int unsigned N_ADD_RS      = 3;
    localparam int unsigned N_MUL_RS      = 2;
    localparam int unsigned ADD_TAG_FIRST = 1;
    localparam int unsigned MUL_TAG_FIRST = ADD_TAG_FIRST + N_ADD_RS;

    typedef enum logic [1:0] {
        OCIOSO,
        DESPACHA,
        PARADO,
        FIM
    } estado_t;

endpackage

// File: rtl/tabela_status_reg.sv
// Register status table (Qi): producer tag per architectural register,
// two bypassing read ports, one rename write port, CDB clear.
module tabela_status_reg
    import tomasulo_pkg::*;
#(
    parameter int unsigned NREG = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [REG_W-1:0] ra_j,
    input  logic [REG_W-1:0] ra_k,
    output logic [TAG_W-1:0] q_j,
    output logic [TAG_W-1:0] q_k,
    input  logic             we,
    input  logic [REG_W-1:0] wa,
    input  logic [TAG_W-1:0] wd,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag
);

    logic [TAG_W-1:0] qi [NREG];

    // A tag broadcast this cycle is already resolved for the reader.
    always_comb begin
        q_j = qi[ra_j];
        q_k = qi[ra_k];
        if (cdb_valid && q_j == cdb_tag) q_j = TAG_NONE;
        if (cdb_valid && q_k == cdb_tag) q_k = TAG_NONE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NREG; i++) qi[i] <= TAG_NONE;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (we && wa == REG_W'(i))
                    qi[i] <= wd;
                else if (cdb_valid && qi[i] == cdb_tag)
                    qi[i] <= TAG_NONE;
            end
        end
    end

endmodule

// File: rtl/unidade_despacho.sv
// Issue stage: decodes the queue head, allocates a reservation station,
// renames the destination and emits a registered issue bundle.
module unidade_despacho
    import tomasulo_pkg::*;
#(
    parameter int unsigned NREG  = 8,
    parameter int unsigned N_ADD = N_ADD_RS,
    parameter int unsigned N_MUL = N_MUL_RS
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [15:0]      instrucao,
    input  logic             instr_valid,
    input  logic [N_ADD-1:0] rs_add_livre,
    input  logic [N_MUL-1:0] rs_mul_livre,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             sinal,
    output logic             issue_valid,
    output logic [TAG_W-1:0] issue_tag,
    output logic [3:0]       issue_op,
    output logic [REG_W-1:0] issue_rs,
    output logic [REG_W-1:0] issue_rt,
    output logic [TAG_W-1:0] issue_qj,
    output logic [TAG_W-1:0] issue_qk,
    output logic             halted
);

    estado_t          estado;
    logic [3:0]       op;
    logic [REG_W-1:0] rd, rs, rt;
    logic [2:0]       unused_campo;
    logic             is_add, is_mul, is_halt;
    logic [N_ADD-1:0] add_disp;
    logic [N_MUL-1:0] mul_disp;
    logic             aloca_ok;
    logic [TAG_W-1:0] aloca_tag;
    logic             emite;
    logic [TAG_W-1:0] q_j, q_k;

    assign op           = instrucao[OP_MSB:OP_LSB];
    assign rd           = instrucao[RD_MSB:RD_LSB];
    assign rs           = instrucao[RS_MSB:RS_LSB];
    assign rt           = instrucao[RT_MSB:RT_LSB];
    assign unused_campo = instrucao[2:0];

    assign is_add  = (op == OP_ADD) || (op == OP_SUB);
    assign is_mul  = (op == OP_MUL) || (op == OP_DIV);
    assign is_halt = (op == OP_HALT);

    // The station picked last edge still reads as free until its own
    // register catches the bundle, so hide that tag for one cycle.
    always_comb begin
        add_disp  = rs_add_livre;
        mul_disp  = rs_mul_livre;
        aloca_ok  = 1'b0;
        aloca_tag = TAG_NONE;
        for (int unsigned i = 0; i < N_ADD; i++)
            if (issue_valid && issue_tag == TAG_W'(ADD_TAG_FIRST + i)) add_disp[i] = 1'b0;
        for (int unsigned i = 0; i < N_MUL; i++)
            if (issue_valid && issue_tag == TAG_W'(MUL_TAG_FIRST + i)) mul_disp[i] = 1'b0;
        if (is_add) begin
            for (int unsigned i = 0; i < N_ADD; i++)
                if (add_disp[i] && !aloca_ok) begin
                    aloca_ok  = 1'b1;
                    aloca_tag = TAG_W'(ADD_TAG_FIRST + i);
                end
        end else if (is_mul) begin
            for (int unsigned i = 0; i < N_MUL; i++)
                if (mul_disp[i] && !aloca_ok) begin
                    aloca_ok  = 1'b1;
                    aloca_tag = TAG_W'(MUL_TAG_FIRST + i);
                end
        end
    end

    assign emite = instr_valid && aloca_ok && (estado != FIM);

    tabela_status_reg #(.NREG(NREG)) u_tabela (
        .clock     (clock),
        .resetn    (resetn),
        .ra_j      (rs),
        .ra_k      (rt),
        .q_j       (q_j),
        .q_k       (q_k),
        .we        (emite),
        .wa        (rd),
        .wd        (aloca_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado      <= OCIOSO;
            sinal       <= 1'b0;
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            issue_op    <= '0;
            issue_rs    <= '0;
            issue_rt    <= '0;
            issue_qj    <= '0;
            issue_qk    <= '0;
            halted      <= 1'b0;
        end else begin
            sinal       <= 1'b0;
            issue_valid <= 1'b0;
            if (estado != FIM) begin
                if (!instr_valid) begin
                    estado <= OCIOSO;
                end else if (is_halt) begin
                    estado <= FIM;
                    halted <= 1'b1;
                end else if (is_add || is_mul) begin
                    if (aloca_ok) begin
                        estado      <= DESPACHA;
                        sinal       <= 1'b1;
                        issue_valid <= 1'b1;
                        issue_tag   <= aloca_tag;
                        issue_op    <= op;
                        issue_rs    <= rs;
                        issue_rt    <= rt;
                        issue_qj    <= q_j;
                        issue_qk    <= q_k;
                    end else begin
                        estado <= PARADO;
                    end
                end else begin
                    estado <= DESPACHA;
                    sinal  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_unidade_despacho.sv
// Directed bench for unidade_despacho; the bench also plays the instruction
// queue, popping its head on the falling edge while sinal is high.
module tb_unidade_despacho;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] instrucao;
    logic        instr_valid;
    logic [2:0]  rs_add_livre;
    logic [1:0]  rs_mul_livre;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic        sinal, issue_valid, halted;
    logic [2:0]  issue_tag, issue_rs, issue_rt, issue_qj, issue_qk;
    logic [3:0]  issue_op;

    logic [15:0] prog [4];
    int          head, cnt;
    int          ncmp = 0;
    int          nerr = 0;

    logic [20:0] bundle;
    logic [2:0]  ctl;
    assign bundle = {issue_valid, sinal, issue_tag, issue_op, issue_rs, issue_rt, issue_qj, issue_qk};
    assign ctl    = {issue_valid, sinal, halted};

    unidade_despacho #(.NREG(8), .N_ADD(3), .N_MUL(2)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .instrucao    (instrucao),
        .instr_valid  (instr_valid),
        .rs_add_livre (rs_add_livre),
        .rs_mul_livre (rs_mul_livre),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .sinal        (sinal),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .issue_op     (issue_op),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_qj     (issue_qj),
        .issue_qk     (issue_qk),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetn && sinal && head < cnt) head = head + 1;
        instr_valid = (head < cnt);
        instrucao   = instr_valid ? prog[head] : 16'h0000;
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, rs, rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    task automatic carrega(input logic [15:0] a, b, c, d, input int n);
        @(negedge clock); #1;
        prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
        head = 0; cnt = n;
        instr_valid = (cnt > 0);
        instrucao   = instr_valid ? prog[0] : 16'h0000;
    endtask

    task automatic borda;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        head = 0; cnt = 0;
        instr_valid = 1'b0; instrucao = 16'h0000;
        rs_add_livre = 3'b111; rs_mul_livre = 2'b11;
        cdb_valid = 1'b0; cdb_tag = 3'd0;
        borda; borda;
        ncmp++; if (bundle !== 21'h0) begin nerr++; $display("FAIL reset_bundle got=%h want=%h", bundle, 21'h0); end
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL reset_ctl got=%b want=%b", ctl, 3'b000); end
        @(negedge clock); resetn = 1'b1;
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL idle_after_reset got=%b want=%b", ctl, 3'b000); end
    endtask

    task automatic test_chain;
        carrega(enc(4'h0, 3'd6, 3'd2, 3'd4), enc(4'h5, 3'd3, 3'd6, 3'd6), 16'h0, 16'h0, 2);
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd1, 4'h0, 3'd2, 3'd4, 3'd0, 3'd0}) begin nerr++;
            $display("FAIL chain_add got=%h want=%h", bundle, {2'b11, 3'd1, 4'h0, 3'd2, 3'd4, 3'd0, 3'd0}); end
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd4, 4'h5, 3'd6, 3'd6, 3'd1, 3'd1}) begin nerr++;
            $display("FAIL chain_mul got=%h want=%h", bundle, {2'b11, 3'd4, 4'h5, 3'd6, 3'd6, 3'd1, 3'd1}); end
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL chain_drain got=%b want=%b", ctl, 3'b000); end
    endtask

    task automatic test_stall;
        rs_add_livre = 3'b000;
        carrega(enc(4'h1, 3'd5, 3'd1, 3'd2), 16'h0, 16'h0, 16'h0, 1);
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL stall_1 got=%b want=%b", ctl, 3'b000); end
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL stall_2 got=%b want=%b", ctl, 3'b000); end
        @(negedge clock); #1; rs_add_livre = 3'b010;
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd2, 4'h1, 3'd1, 3'd2, 3'd0, 3'd0}) begin nerr++;
            $display("FAIL stall_release got=%h want=%h", bundle, {2'b11, 3'd2, 4'h1, 3'd1, 3'd2, 3'd0, 3'd0}); end
        @(negedge clock); #1; rs_add_livre = 3'b111;
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL stall_single_pulse got=%b want=%b", ctl, 3'b000); end
    endtask

    task automatic test_cdb_bypass;
        carrega(enc(4'h0, 3'd1, 3'd6, 3'd6), enc(4'h5, 3'd7, 3'd1, 3'd6), 16'h0, 16'h0, 2);
        cdb_valid = 1'b1; cdb_tag = 3'd1;
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd1, 4'h0, 3'd6, 3'd6, 3'd0, 3'd0}) begin nerr++;
            $display("FAIL cdb_bypass got=%h want=%h", bundle, {2'b11, 3'd1, 4'h0, 3'd6, 3'd6, 3'd0, 3'd0}); end
        @(negedge clock); #1; cdb_valid = 1'b0;
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd4, 4'h5, 3'd1, 3'd6, 3'd1, 3'd0}) begin nerr++;
            $display("FAIL cdb_cleared got=%h want=%h", bundle, {2'b11, 3'd4, 4'h5, 3'd1, 3'd6, 3'd1, 3'd0}); end
        borda;
    endtask

    task automatic test_priority;
        carrega(enc(4'h0, 3'd3, 3'd3, 3'd0), enc(4'h1, 3'd2, 3'd3, 3'd7), 16'h0, 16'h0, 2);
        cdb_valid = 1'b1; cdb_tag = 3'd4;
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd1, 4'h0, 3'd3, 3'd0, 3'd0, 3'd0}) begin nerr++;
            $display("FAIL prio_issue got=%h want=%h", bundle, {2'b11, 3'd1, 4'h0, 3'd3, 3'd0, 3'd0, 3'd0}); end
        @(negedge clock); #1; cdb_valid = 1'b0;
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd2, 4'h1, 3'd3, 3'd7, 3'd1, 3'd0}) begin nerr++;
            $display("FAIL prio_write_wins got=%h want=%h", bundle, {2'b11, 3'd2, 4'h1, 3'd3, 3'd7, 3'd1, 3'd0}); end
        borda;
    endtask

    task automatic test_nop_halt;
        carrega(enc(4'h3, 3'd2, 3'd1, 3'd1), enc(4'h1, 3'd4, 3'd2, 3'd3),
                enc(4'hF, 3'd0, 3'd0, 3'd0), enc(4'h0, 3'd0, 3'd0, 3'd0), 4);
        borda;
        ncmp++; if (ctl !== 3'b010) begin nerr++; $display("FAIL nop_ctl got=%b want=%b", ctl, 3'b010); end
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd1, 4'h1, 3'd2, 3'd3, 3'd2, 3'd1}) begin nerr++;
            $display("FAIL nop_qi_kept got=%h want=%h", bundle, {2'b11, 3'd1, 4'h1, 3'd2, 3'd3, 3'd2, 3'd1}); end
        for (int i = 0; i < 3; i++) begin
            borda;
            ncmp++; if (ctl !== 3'b001) begin nerr++; $display("FAIL halt_hold[%0d] got=%b want=%b", i, ctl, 3'b001); end
        end
        @(negedge clock); #1; resetn = 1'b0; cnt = 0; head = 0;
        instr_valid = 1'b0; instrucao = 16'h0000;
        #1;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL halt_reset_ctl got=%b want=%b", ctl, 3'b000); end
        @(negedge clock); #1; resetn = 1'b1;
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL halt_left got=%b want=%b", ctl, 3'b000); end
    endtask

    task automatic test_back_to_back;
        carrega(enc(4'h0, 3'd1, 3'd2, 3'd3), enc(4'h0, 3'd4, 3'd1, 3'd1),
                enc(4'h0, 3'd6, 3'd4, 3'd0), enc(4'h5, 3'd5, 3'd4, 3'd1), 4);
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd1, 4'h0, 3'd2, 3'd3, 3'd0, 3'd0}) begin nerr++;
            $display("FAIL b2b_0 got=%h want=%h", bundle, {2'b11, 3'd1, 4'h0, 3'd2, 3'd3, 3'd0, 3'd0}); end
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd2, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1}) begin nerr++;
            $display("FAIL b2b_1 got=%h want=%h", bundle, {2'b11, 3'd2, 4'h0, 3'd1, 3'd1, 3'd1, 3'd1}); end
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd1, 4'h0, 3'd4, 3'd0, 3'd2, 3'd0}) begin nerr++;
            $display("FAIL b2b_2 got=%h want=%h", bundle, {2'b11, 3'd1, 4'h0, 3'd4, 3'd0, 3'd2, 3'd0}); end
        borda;
        ncmp++; if (bundle !== {2'b11, 3'd4, 4'h5, 3'd4, 3'd1, 3'd2, 3'd1}) begin nerr++;
            $display("FAIL b2b_3 got=%h want=%h", bundle, {2'b11, 3'd4, 4'h5, 3'd4, 3'd1, 3'd2, 3'd1}); end
        resetn = 1'b0; cnt = 0; head = 0;
        instr_valid = 1'b0; instrucao = 16'h0000;
        #1;
        ncmp++; if (bundle !== 21'h0) begin nerr++; $display("FAIL midreset_bundle got=%h want=%h", bundle, 21'h0); end
        @(negedge clock); #1; resetn = 1'b1;
        borda;
        ncmp++; if (ctl !== 3'b000) begin nerr++; $display("FAIL midreset_idle got=%b want=%b", ctl, 3'b000); end
    endtask

    initial begin
        test_reset;
        test_chain;
        test_stall;
        test_cdb_bypass;
        test_priority;
        test_nop_halt;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
